// File: rtl/mod_shift_reduce.sv
// mod_shift_reduce: result = (num_in * 2^len) mod modulus via restoring shift-subtract
module mod_shift_reduce #(
    parameter int W     = 32,
    parameter int LEN_W = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     num_in,
    input  logic [W-1:0]     modulus,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     result
);
    localparam int CW = LEN_W + $clog2(W) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] n_q, n_d, m_q, m_d, result_q, result_d, n_s;
    logic [W:0] r_q, r_d, r_s, t;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    // STEP chained iterations; the dividend shifts out MSB-first with zeros trailing, stages past the remaining count hold r
    always_comb begin
        r_s = r_q;
        n_s = n_q;
        t = '0;
        for (int i = 0; i < STEP; i++) begin
            t = {r_s[W-1:0], n_s[W-1]};
            t = t >= {1'b0, m_q} ? t - {1'b0, m_q} : t;
            r_s = CW'(i) < cnt_q ? t : r_s;
            n_s = CW'(i) < cnt_q ? n_s << 1 : n_s;
        end
    end
    // control: accept in IDLE, iterate in CALC, latch result on the edge entering DONE
    always_comb begin
        state_d = state_q;
        n_d = n_q;
        m_d = m_q;
        r_d = r_q;
        cnt_d = cnt_q;
        result_d = result_q;
        err_d = err_q;
        if (state_q == IDLE && start) begin
            n_d = num_in;
            m_d = modulus;
            r_d = '0;
            cnt_d = CW'(W) + CW'(len);
            state_d = modulus == '0 ? DONE : CALC;
            result_d = modulus == '0 ? '0 : result_q;
            err_d = modulus == '0 ? 1'b1 : err_q;
        end else if (state_q == CALC) begin
            n_d = n_s;
            r_d = r_s;
            cnt_d = cnt_q > CW'(STEP) ? cnt_q - CW'(STEP) : '0;
            state_d = abort ? IDLE : cnt_d == '0 ? DONE : CALC;
            result_d = !abort && cnt_d == '0 ? r_s[W-1:0] : result_q;
            err_d = !abort && cnt_d == '0 ? 1'b0 : err_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q <= '0;
            m_q <= '0;
            r_q <= '0;
            cnt_q <= '0;
            result_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            m_q <= m_d;
            r_q <= r_d;
            cnt_q <= cnt_d;
            result_q <= result_d;
            err_q <= err_d;
        end
    end
    assign ready = state_q == IDLE;
    assign done = state_q == DONE;
    assign err = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_mod_shift_reduce.sv
// tb_mod_shift_reduce: directed checks of the modular pre-scaler for STEP = 1, 2, 4
module tb_mod_shift_reduce;
    logic clk, rst, abort;
    logic [7:0] len;
    logic [31:0] num_in, modulus;
    logic st [3];
    logic rdy [3];
    logic dn [3];
    logic er_v [3];
    logic [31:0] res [3];
    int errors = 0, checks = 0;

    mod_shift_reduce #(.W(32), .LEN_W(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .start(st[0]), .abort(abort),
        .len(len), .num_in(num_in), .modulus(modulus), .ready(rdy[0]), .done(dn[0]), .err(er_v[0]), .result(res[0]));
    mod_shift_reduce #(.W(32), .LEN_W(8), .STEP(2)) dut2 (.clk(clk), .rst(rst), .start(st[1]), .abort(abort),
        .len(len), .num_in(num_in), .modulus(modulus), .ready(rdy[1]), .done(dn[1]), .err(er_v[1]), .result(res[1]));
    mod_shift_reduce #(.W(32), .LEN_W(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .start(st[2]), .abort(abort),
        .len(len), .num_in(num_in), .modulus(modulus), .ready(rdy[2]), .done(dn[2]), .err(er_v[2]), .result(res[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one operation on DUT d; latency counted from the start cycle to the done cycle
    task automatic run(input string name, input int d, input logic [31:0] n, input logic [7:0] l,
                       input logic [31:0] m, input logic [31:0] exp_res, input logic exp_err,
                       input int lat, input int pulse);
        logic [31:0] prev;
        int k, bad_rdy, bad_res;
        prev = res[d];
        bad_rdy = 0;
        bad_res = 0;
        num_in = n;
        len = l;
        modulus = m;
        st[d] = 1;
        @(negedge clk);
        st[d] = 0;
        k = 1;
        while (!dn[d] && k < 200) begin
            if (rdy[d]) bad_rdy++;
            if (res[d] !== prev) bad_res++;
            if (k == pulse) begin
                st[d] = 1;
                modulus = '0;
            end else st[d] = 0;
            @(negedge clk);
            k++;
        end
        st[d] = 0;
        chk({name, "/latency"}, k, lat);
        chk({name, "/result"}, res[d], exp_res);
        chk({name, "/err"}, er_v[d], exp_err);
        chk({name, "/ready_low"}, bad_rdy, 0);
        chk({name, "/result_hold"}, bad_res, 0);
        @(negedge clk);
        chk({name, "/ready_back"}, rdy[d], 1);
        chk({name, "/done_pulse"}, dn[d], 0);
    endtask

    initial begin
        int k, dcount;
        rst = 1;
        abort = 0;
        st[0] = 0;
        st[1] = 0;
        st[2] = 0;
        len = 0;
        num_in = 0;
        modulus = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset/ready", rdy[0], 1);
        chk("reset/done", dn[0], 0);
        chk("reset/err", er_v[0], 0);
        chk("reset/result", res[0], 0);

        run("s1_80mod7", 0, 32'd5, 8'd4, 32'd7, 32'd3, 0, 37, 0);
        run("s1_big", 0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB, 32'h14, 0, 65, 0);
        run("s1_n_ge_m", 0, 32'd9, 8'd0, 32'd4, 32'd1, 0, 33, 0);
        run("s1_mod0", 0, 32'd123, 8'd5, 32'd0, 32'd0, 1, 1, 0);
        run("s1_mod1", 0, 32'd77, 8'd3, 32'd1, 32'd0, 0, 36, 0);

        // start held high: second operation only begins after DONE -> IDLE
        num_in = 32'd5;
        len = 8'd4;
        modulus = 32'd7;
        st[0] = 1;
        k = 0;
        while (!dn[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("held/lat1", k, 37);
        chk("held/res1", res[0], 3);
        num_in = 32'd9;
        len = 8'd0;
        modulus = 32'd4;
        @(negedge clk);
        chk("held/idle_gap", rdy[0], 1);
        k = 1;
        @(negedge clk);
        chk("held/restarted", rdy[0], 0);
        k = 2;
        while (!dn[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        st[0] = 0;
        chk("held/lat2", k, 34);
        chk("held/res2", res[0], 1);
        @(negedge clk);

        run("s1_pulse", 0, 32'd10, 8'd3, 32'd13, 32'd2, 0, 36, 5);
        run("s4", 2, 32'd10, 8'd3, 32'd13, 32'd2, 0, 10, 0);
        run("s2", 1, 32'd10, 8'd3, 32'd13, 32'd2, 0, 19, 0);

        // abort in the 10th CALC cycle
        num_in = 32'd5;
        len = 8'd4;
        modulus = 32'd7;
        st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        repeat (9) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort/ready", rdy[0], 1);
        chk("abort/done", dn[0], 0);
        chk("abort/result", res[0], 2);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn[0]) dcount++;
        end
        chk("abort/no_done", dcount, 0);

        // rst mid-CALC
        num_in = 32'd9;
        len = 8'd0;
        modulus = 32'd4;
        st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst/ready", rdy[0], 1);
        chk("rst/done", dn[0], 0);
        chk("rst/err", er_v[0], 0);
        chk("rst/result", res[0], 0);

        run("after_rst", 0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB, 32'h14, 0, 65, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_shift_reduce.md
# mod_shift_reduce

Parametrised modular pre-scaler: computes result = (num_in · 2^len) mod modulus with a restoring shift-subtract datapath. It is the generic successor of the fixed 32-bit R-scaling divider and feeds operands into the Montgomery domain ahead of the modular multiplier. Compared with that divider it adds:
- configurable operand width and iterations per cycle;
- a ready/start/done handshake with a held result;
- abort;
- a divide-by-zero error flag.

## Interface
- W, default 32: operand/result width in bits (≥ 4).
- LEN_W, default 8: width of len; shift amount 0 … 2^LEN_W−1.
- STEP, default 1: shift-subtract iterations per clock; legal values 1, 2, 4.

Ports (reset is synchronous, active-high; one clock domain):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only in a cycle where ready = 1.
- abort  in  1  cancels a running operation; returns to IDLE, no done.
- len  in  LEN_W  shift exponent; sampled on accepted start.
- num_in  in  W  operand; sampled on accepted start; any value, including ≥ modulus.
- modulus  in  W  modulus; sampled on accepted start.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  valid with done; 1 when modulus = 0.
- result  out  W  registered; holds last completed value until the next done.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on start with modulus ≠ 0.
- IDLE → DONE on start with modulus = 0: err = 1, result = 0, no CALC cycles.
- On accept, the block captures:
  - n = num_in, m = modulus;
  - remainder r = 0 (W+1 bits);
  - iteration count K = W + len (width LEN_W+ceil(log2 W)+1, no overflow).
- Each iteration consumes the next dividend bit MSB-first. Dividend bits are num_in[W−1]…num_in[0], followed by len zero bits.
  - r ← 2r + bit;
  - if r ≥ m then r ← r − m.
- STEP iterations are chained combinationally per cycle. The final cycle executes only the remaining K mod STEP iterations (if non-zero); extra stages pass r unchanged.
- CALC → DONE when the remaining count reaches 0. In DONE, result ← r[W−1:0], err ← 0, done = 1.
- DONE → IDLE unconditionally next cycle.
- abort in CALC → IDLE next cycle. result and err are unchanged; done is not asserted. abort in IDLE or DONE is ignored.
- start while ready = 0 is ignored (no queueing).
- r < m holds after every iteration, so r fits W+1 bits and the final result < m.
- modulus = 1 yields result 0, err 0.

## Timing
- Reset values: state IDLE, ready 1, done 0, err 0, result 0, internal regs 0.
- rst overrides everything, including mid-CALC and the DONE cycle; the following cycle is IDLE with done = 0.
- Start accepted at edge t: CALC occupies edges t+1 … t+C, where C = ceil((W+len)/STEP). DONE is visible in the cycle after edge t+C. ready returns in the following cycle.
- Total latency from the start cycle to the done cycle: C+1 cycles. Zero-modulus case: 1 cycle.
- Back-to-back: the earliest next start is in the first cycle after DONE.
- result and err change only at the edge entering DONE, or on rst.
- abort and a final CALC cycle at the same edge: abort wins, no done.

## Test plan
- W=32, STEP=1: num_in=5, len=4, modulus=7 → result=3 (80 mod 7), err=0; done exactly 37 cycles after the start cycle; ready low throughout.
- W=32, STEP=1: num_in=0xFFFFFFFF, len=32, modulus=0xFFFFFFFB → result=20 (0x14). num_in=9, len=0, modulus=4 → result=1 (num_in ≥ modulus case).
- W=32, STEP=4: num_in=10, len=3, modulus=13 → result=2; K=35 → C=9 CALC cycles, done 10 cycles after start. Repeat with STEP=2 → C=18; result identical.
- modulus=0, num_in=123, len=5 → done the next cycle with err=1, result=0. Then modulus=1 → result=0, err=0.
- Handshake:
  - start held high continuously: a second operation begins only after DONE → IDLE;
  - start pulsed mid-CALC: ignored;
  - result stays stable between completions.
- abort, then rst:
  - abort at CALC cycle 10 → IDLE next cycle, no done, result keeps the previous value;
  - rst during CALC → all outputs at reset values;
  - a subsequent start completes correctly.
